// File: rtl/peripheral_msi_ahb2apb4_bridge_if.sv
// Bus interfaces for the AHB-Lite to APB4 bridge: the AHB-Lite slave-side
// port and the APB4 peripheral port, each with master/slave modports.
interface peripheral_msi_ahb_if #(
    parameter int PLEN = 64,
    parameter int XLEN = 64
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HREADYOUT;
    logic            HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

interface peripheral_msi_apb4_if #(
    parameter int PLEN = 64,
    parameter int XLEN = 64
);
    logic              PSEL;
    logic              PENABLE;
    logic [PLEN-1:0]   PADDR;
    logic              PWRITE;
    logic [XLEN-1:0]   PWDATA;
    logic [XLEN/8-1:0] PSTRB;
    logic [2:0]        PPROT;
    logic [XLEN-1:0]   PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/peripheral_msi_ahb2apb4_bridge.sv
// AHB-Lite slave to APB4 master bridge, one transfer in flight, PSLVERR -> AHB ERROR.
// Optional ACCESS-phase timeout: define PERIPHERAL_MSI_APB4_TIMEOUT_EN.
module peripheral_msi_ahb2apb4_bridge #(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    peripheral_msi_ahb_if.slave   ahb,
    peripheral_msi_apb4_if.master apb
);
    localparam int NB = XLEN / 8;
    localparam int SW = $clog2(NB);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("XLEN must be 32 or 64");
    end

    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t          state_q, state_d;
    logic            accept;
    logic            timeout_hit;
    logic            psel_q, penable_q, pwrite_q;
    logic [PLEN-1:0] paddr_q;
    logic [XLEN-1:0] pwdata_q, hrdata_q;
    logic [NB-1:0]   pstrb_q;
    logic [2:0]      pprot_q, size_q;
    logic            hreadyout_q, hresp_q;
    logic            unused_inputs;

    assign unused_inputs = ^{ahb.HBURST, ahb.HMASTLOCK, ahb.HPROT[3:2]};

    assign accept = (state_q == IDLE || state_q == ERR2)
                  && ahb.HSEL && ahb.HREADY && ahb.HTRANS[1];

    // Byte lanes covered by the transfer; lanes past the bus width are clipped.
    function automatic logic [NB-1:0] strobe(input logic [SW-1:0] off, input logic [2:0] size);
        logic [NB-1:0] s;
        int lo, hi;
        s = '0;
        if (int'(size) >= SW) begin
            s = '1;
        end else begin
            lo = int'(off);
            hi = lo + (1 << int'(size));
            for (int i = 0; i < NB; i++) s[i] = (i >= lo) && (i < hi);
        end
        return s;
    endfunction

`ifdef PERIPHERAL_MSI_APB4_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            wait_cnt <= '0;
        else if (state_q == SETUP)
            wait_cnt <= '0;
        else if (state_q == ACCESS && !apb.PREADY)
            wait_cnt <= wait_cnt + CW'(1);
    end

    // The edge that would bring the count to TIMEOUT ends the transfer.
    assign timeout_hit = !apb.PREADY && (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: state_d gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, ERR2: begin
                if (accept) state_d = ahb.HWRITE ? WDATA : SETUP;
                else        state_d = IDLE;
            end
            WDATA:  state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (apb.PREADY)       state_d = apb.PSLVERR ? ERR1 : IDLE;
                else if (timeout_hit) state_d = ERR1;
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    // Bus-facing handshake outputs are registered from the next state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q   <= (state_d == ACCESS);
            hreadyout_q <= (state_d == IDLE) || (state_d == ERR2);
            hresp_q     <= (state_d == ERR1) || (state_d == ERR2);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            size_q   <= '0;
            hrdata_q <= '0;
        end else begin
            if (accept) begin
                paddr_q  <= ahb.HADDR;
                pwrite_q <= ahb.HWRITE;
                size_q   <= ahb.HSIZE;
                pprot_q  <= {~ahb.HPROT[0], 1'b1, ahb.HPROT[1]};
                if (!ahb.HWRITE) pstrb_q <= '0;
            end
            if (state_q == WDATA) begin
                pwdata_q <= ahb.HWDATA;
                pstrb_q  <= strobe(paddr_q[SW-1:0], size_q);
            end
            if (state_q == ACCESS && apb.PREADY && !apb.PSLVERR && !pwrite_q)
                hrdata_q <= apb.PRDATA;
        end
    end

    assign ahb.HREADYOUT = hreadyout_q;
    assign ahb.HRESP     = hresp_q;
    assign ahb.HRDATA    = hrdata_q;
    assign apb.PSEL      = psel_q;
    assign apb.PENABLE   = penable_q;
    assign apb.PADDR     = paddr_q;
    assign apb.PWRITE    = pwrite_q;
    assign apb.PWDATA    = pwdata_q;
    assign apb.PSTRB     = pstrb_q;
    assign apb.PPROT     = pprot_q;
endmodule
